// File: rtl/perf_monitor.sv
// Windowed multi-channel event counter keyed on CPU pc; closes on FINAL_PC or stall.
// Flags and counters update on the edge; rd_nibble has 1-cycle latency; no backpressure.
module perf_monitor #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int PC_WIDTH     = 12,
  parameter int START_PC     = 0,
  parameter int FINAL_PC     = 4095,
  parameter int STALL_LIMIT  = 16,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DIG_W = (COUNT_WIDTH > 4) ? $clog2(COUNT_WIDTH / 4) : 1
) (
  input  logic                    CLK_50,
  input  logic                    resetN,
  input  logic                    clear,
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [NUM_CHANNELS-1:0] event_in,
  input  logic [CH_W-1:0]         rd_channel,
  input  logic [DIG_W-1:0]        rd_digit,
  output logic [3:0]              rd_nibble,
  output logic                    running,
  output logic                    done,
  output logic                    stalled,
  output logic [NUM_CHANNELS-1:0] overflow
);

  localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [PC_WIDTH-1:0] START_V   = PC_WIDTH'(START_PC);
  localparam logic [PC_WIDTH-1:0] FINAL_V   = PC_WIDTH'(FINAL_PC);
  localparam logic [SW-1:0]       STALL_MAX = SW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   stalled_nxt;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [SW-1:0]          stall_cnt, stall_cnt_nxt;
  logic [COUNT_WIDTH-1:0] cnt [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] sel, shifted;
  logic                   at_start, at_final, pc_same, stall_hit, cnt_en;

  assign at_start  = (pc == START_V);
  assign at_final  = (pc == FINAL_V);
  assign pc_same   = (pc == pc_q);
  assign stall_hit = pc_same && (stall_cnt == STALL_MAX);

  always_comb begin
    state_nxt   = state;
    stalled_nxt = stalled;
    case (state)
      IDLE: if (at_start) state_nxt = at_final ? DONE : RUN;
      RUN: begin
        // FINAL_PC wins over the stall detector, so stalled stays clear.
        if (at_final) begin
          state_nxt = DONE;
        end else if (stall_hit) begin
          state_nxt   = DONE;
          stalled_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt   = IDLE;
      stalled_nxt = 1'b0;
    end
  end

  always_comb begin
    cnt_en        = !clear && ((state == RUN) || ((state == IDLE) && at_start));
    stall_cnt_nxt = '0;
    if (!clear && (state == RUN) && (state_nxt == RUN) && pc_same)
      stall_cnt_nxt = stall_cnt + SW'(1);
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (rd_channel == CH_W'(i)) sel = cnt[i];
    shifted = sel >> {rd_digit, 2'b00};
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
      stalled   <= 1'b0;
      pc_q      <= '0;
      stall_cnt <= '0;
      rd_nibble <= '0;
      overflow  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      running   <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      stalled   <= stalled_nxt;
      pc_q      <= pc;
      stall_cnt <= stall_cnt_nxt;
      rd_nibble <= shifted[3:0];
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (clear) begin
          cnt[i]      <= '0;
          overflow[i] <= 1'b0;
        end else if (cnt_en && event_in[i]) begin
          // Saturate: an event arriving at all-ones is lost and flagged.
          if (&cnt[i]) overflow[i] <= 1'b1;
          else         cnt[i]      <= cnt[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit instance and an 8-bit instance share stimulus;
// read results go through an expectation queue and are checked one cycle later.
module tb_perf_monitor;

  logic        CLK_50 = 1'b0;
  logic        resetN = 1'b0;
  logic        clear  = 1'b0;
  logic [11:0] pc;
  logic [4:0]  event_in;
  logic [2:0]  rd_channel;
  logic [2:0]  rd_digit;
  logic [3:0]  rd_nibble, rd_nibble8;
  logic        running, done, stalled, running8, done8, stalled8;
  logic [4:0]  overflow, overflow8;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [3:0] n; logic [3:0] n8; bit chk8; string name; } rd_exp_t;
  typedef struct { logic [11:0] pc; logic [4:0] ev; logic run; logic dn; } win_vec_t;
  typedef struct { logic [2:0] ch; logic [2:0] dig; logic [3:0] exp; } rd_vec_t;

  rd_exp_t  sb[$];
  win_vec_t wv[13];
  rd_vec_t  rv[11];

  perf_monitor #(.NUM_CHANNELS(5), .COUNT_WIDTH(32), .PC_WIDTH(12), .START_PC(0),
                 .FINAL_PC(10), .STALL_LIMIT(16)) dut (
    .CLK_50(CLK_50), .resetN(resetN), .clear(clear), .pc(pc), .event_in(event_in),
    .rd_channel(rd_channel), .rd_digit(rd_digit), .rd_nibble(rd_nibble),
    .running(running), .done(done), .stalled(stalled), .overflow(overflow));

  perf_monitor #(.NUM_CHANNELS(5), .COUNT_WIDTH(8), .PC_WIDTH(12), .START_PC(0),
                 .FINAL_PC(10), .STALL_LIMIT(16)) dut8 (
    .CLK_50(CLK_50), .resetN(resetN), .clear(clear), .pc(pc), .event_in(event_in),
    .rd_channel(rd_channel), .rd_digit(rd_digit[0:0]), .rd_nibble(rd_nibble8),
    .running(running8), .done(done8), .stalled(stalled8), .overflow(overflow8));

  always #5 CLK_50 = ~CLK_50;

  task automatic step();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd_issue(input string name, input logic [2:0] ch, input logic [2:0] dig,
                          input logic [3:0] n, input logic [3:0] n8, input bit chk8);
    rd_exp_t e;
    rd_channel = ch;
    rd_digit   = dig;
    e.n = n; e.n8 = n8; e.chk8 = chk8; e.name = name;
    sb.push_back(e);
  endtask

  task automatic rd_check();
    rd_exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: no expectation queued for a read result");
    end else begin
      e = sb.pop_front();
      check(e.name, {28'd0, rd_nibble}, {28'd0, e.n});
      if (e.chk8) check({e.name, "_w8"}, {28'd0, rd_nibble8}, {28'd0, e.n8});
    end
  endtask

  task automatic read1(input string name, input logic [2:0] ch, input logic [2:0] dig,
                       input logic [3:0] n, input logic [3:0] n8, input bit chk8);
    rd_issue(name, ch, dig, n, n8, chk8);
    step();
    rd_check();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // Window 0..10 with channel 0 counting every cycle.
    for (int i = 0; i <= 10; i++) wv[i] = '{pc: 12'(i), ev: 5'b00001, run: (i < 10), dn: (i == 10)};
    wv[11] = '{pc: 12'd0,  ev: 5'b00001, run: 1'b0, dn: 1'b1};
    wv[12] = '{pc: 12'd10, ev: 5'b00001, run: 1'b0, dn: 1'b1};
    // Sweep of a 0x1234 count on channel 1, plus out-of-range channels.
    for (int d = 0; d < 8; d++) rv[d].ch = 3'd1;
    for (int d = 0; d < 8; d++) rv[d].dig = 3'(d);
    rv[0].exp = 4'h4; rv[1].exp = 4'h3; rv[2].exp = 4'h2; rv[3].exp = 4'h1;
    rv[4].exp = 4'h0; rv[5].exp = 4'h0; rv[6].exp = 4'h0; rv[7].exp = 4'h0;
    rv[8]  = '{ch: 3'd5, dig: 3'd0, exp: 4'h0};
    rv[9]  = '{ch: 3'd7, dig: 3'd1, exp: 4'h0};
    rv[10] = '{ch: 3'd0, dig: 3'd0, exp: 4'h0};

    pc = 12'h100; event_in = '0; rd_channel = '0; rd_digit = '0;
    repeat (3) step();
    check("rst_running",  {31'd0, running},  32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_stalled",  {31'd0, stalled},  32'd0);
    check("rst_overflow", {27'd0, overflow}, 32'd0);
    check("rst_nibble",   {28'd0, rd_nibble}, 32'd0);
    resetN = 1'b1;
    step();
    check("idle_no_arm", {31'd0, running}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      pc = wv[i].pc;
      event_in = wv[i].ev;
      step();
      check($sformatf("win_running_%0d", i), {31'd0, running}, {31'd0, wv[i].run});
      check($sformatf("win_done_%0d", i),    {31'd0, done},    {31'd0, wv[i].dn});
    end
    event_in = '0;
    check("win_stalled", {31'd0, stalled}, 32'd0);
    read1("win_ch0_d0", 3'd0, 3'd0, 4'hB, 4'hB, 1'b1);
    read1("win_ch0_d1", 3'd0, 3'd1, 4'h0, 4'h0, 1'b1);
    read1("win_ch1_d0", 3'd1, 3'd0, 4'h0, 4'h0, 1'b1);

    // Clear in DONE, then pc==START_PC on the following cycle re-arms.
    clear = 1'b1; pc = 12'd3;
    step();
    clear = 1'b0;
    check("clr_done",    {31'd0, done},    32'd0);
    check("clr_running", {31'd0, running}, 32'd0);
    check("clr_stalled", {31'd0, stalled}, 32'd0);
    pc = 12'd0;
    rd_issue("clr_ch0_zero", 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);
    step();
    rd_check();
    check("rearm_running", {31'd0, running}, 32'd1);

    // Stall: pc 4, then 5 held; closes on the 16th edge with pc equal to pc_q.
    event_in = 5'b00001;
    pc = 12'd4; step();
    pc = 12'd5; step();
    for (int k = 1; k <= 15; k++) step();
    check("stall_15_running", {31'd0, running}, 32'd1);
    check("stall_15_done",    {31'd0, done},    32'd0);
    step();
    check("stall_16_done",    {31'd0, done},    32'd1);
    check("stall_16_stalled", {31'd0, stalled}, 32'd1);
    check("stall_16_running", {31'd0, running}, 32'd0);
    repeat (3) step();
    event_in = '0;
    read1("stall_ch0_d0", 3'd0, 3'd0, 4'h2, 4'h2, 1'b1);
    read1("stall_ch0_d1", 3'd0, 3'd1, 4'h1, 4'h1, 1'b1);

    // 300 window cycles on channel 1: saturates the 8-bit instance only.
    do_clear();
    check("post_clr_stalled", {31'd0, stalled}, 32'd0);
    pc = 12'd0; event_in = 5'b00010;
    step();
    for (int j = 0; j < 298; j++) begin
      pc = (j % 2 == 0) ? 12'd1 : 12'd2;
      step();
    end
    pc = 12'd10;
    step();
    event_in = '0;
    check("ovf_done",      {31'd0, done},      32'd1);
    check("ovf_stalled",   {31'd0, stalled},   32'd0);
    check("ovf_flags_w8",  {27'd0, overflow8}, 32'h02);
    check("ovf_flags_w32", {27'd0, overflow},  32'h00);
    read1("ovf_ch1_d0", 3'd1, 3'd0, 4'hC, 4'hF, 1'b1);
    read1("ovf_ch1_d1", 3'd1, 3'd1, 4'h2, 4'hF, 1'b1);
    read1("ovf_ch1_d2", 3'd1, 3'd2, 4'h1, 4'h0, 1'b0);
    read1("ovf_ch0_d0", 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);

    // Build 0x1234 on channel 1, then sweep the read port back to back.
    do_clear();
    pc = 12'd0; event_in = 5'b00010;
    step();
    for (int j = 0; j < 4659; j++) begin
      pc = (j % 2 == 0) ? 12'd1 : 12'd2;
      step();
    end
    pc = 12'd10; event_in = '0;
    step();
    check("sweep_done", {31'd0, done}, 32'd1);
    rd_issue("sweep_0", rv[0].ch, rv[0].dig, rv[0].exp, 4'h0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step();
      rd_check();
      if (i + 1 < 11)
        rd_issue($sformatf("sweep_%0d", i + 1), rv[i+1].ch, rv[i+1].dig, rv[i+1].exp, 4'h0, 1'b0);
    end

    // Read in the same cycle as an increment sees the old value; then async reset mid-RUN.
    do_clear();
    pc = 12'd0; event_in = 5'b00001;
    step();
    pc = 12'd1;
    rd_issue("rd_pre_inc", 3'd0, 3'd0, 4'h1, 4'h1, 1'b1);
    step();
    rd_check();
    pc = 12'd2;
    step();
    check("pre_rst_running", {31'd0, running}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("arst_running",  {31'd0, running},   32'd0);
    check("arst_done",     {31'd0, done},      32'd0);
    check("arst_nibble",   {28'd0, rd_nibble}, 32'd0);
    check("arst_overflow", {27'd0, overflow},  32'd0);
    pc = 12'h100; event_in = '0;
    step();
    resetN = 1'b1;
    step();
    check("post_rst_running", {31'd0, running}, 32'd0);
    check("post_rst_done",    {31'd0, done},    32'd0);
    read1("post_rst_ch0", 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
